// File: rtl/router_port_arbiter.sv
// router_port_arbiter: shares one router output port among N input requesters.
// Round-robin grant that is held for a whole packet (head flit through tail flit),
// with credit-based flow control toward the downstream buffer.
//
// Ports:
//   clk, rst       rising-edge clock, asynchronous active-high reset
//   req_valid[N]   requester i presents a flit
//   req_tail[N]    requester i's current flit ends its packet
//   req_data[N*W]  flit data, requester i at [i*W +: W]
//   req_ready[N]   requester i's flit is accepted this cycle
//   out_valid      flit on out_data is transferred this cycle
//   out_data[W]    forwarded flit
//   out_tail       forwarded flit is a tail flit
//   out_grant[GW]  index of the currently locked requester
//   credit_return  downstream freed one buffer slot (one-cycle pulse)
//   credits[CW]    current credit count
//   busy           a packet lock is held
//   credit_err     sticky: credit returned while already at full credit
module router_port_arbiter #(
   parameter int unsigned N       = 4,
   parameter int unsigned W       = 8,
   parameter int unsigned CREDITS = 4,
   localparam int unsigned GW     = $clog2(N),
   localparam int unsigned CW     = $clog2(CREDITS + 1)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N-1:0]    req_valid,
   input  logic [N-1:0]    req_tail,
   input  logic [N*W-1:0]  req_data,
   output logic [N-1:0]    req_ready,
   output logic            out_valid,
   output logic [W-1:0]    out_data,
   output logic            out_tail,
   output logic [GW-1:0]   out_grant,
   input  logic            credit_return,
   output logic [CW-1:0]   credits,
   output logic            busy,
   output logic            credit_err
);

   typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_t;

   state_t          state, state_nx;
   logic [GW-1:0]   rr_ptr;
   logic [GW-1:0]   pick;
   logic            sel_valid;
   logic            sel_tail;
   logic [W-1:0]    sel_data;
   logic            xfer;

   // Lane selected by the current grant.
   always_comb begin
      sel_valid = 1'b0;
      sel_tail  = 1'b0;
      sel_data  = '0;
      for (int i = 0; i < int'(N); i++) begin
         if (GW'(i) == out_grant) begin
            sel_valid = req_valid[i];
            sel_tail  = req_tail[i];
            sel_data  = req_data[i*W +: W];
         end
      end
   end

   // First valid requester scanning circularly from rr_ptr; the scan runs
   // from the far end down so the nearest hit is written last and wins.
   always_comb begin
      int idx;
      idx  = 0;
      pick = '0;
      for (int k = int'(N) - 1; k >= 0; k--) begin
         idx = int'(rr_ptr) + k;
         if (idx >= int'(N)) idx = idx - int'(N);
         if (req_valid[idx]) pick = GW'(idx);
      end
   end

   // Next state and port-side outputs.
   always_comb begin
      state_nx  = state;
      req_ready = '0;
      out_valid = 1'b0;
      out_data  = '0;
      out_tail  = 1'b0;
      busy      = 1'b0;
      xfer      = 1'b0;
      case (state)
         IDLE: begin
            if (|req_valid) state_nx = LOCK;
         end
         LOCK: begin
            busy      = 1'b1;
            xfer      = sel_valid & (credits != '0);
            out_valid = xfer;
            out_data  = sel_data;
            out_tail  = sel_tail;
            for (int i = 0; i < int'(N); i++) begin
               if (GW'(i) == out_grant) req_ready[i] = xfer;
            end
            if (xfer && sel_tail) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // State, grant and round-robin pointer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         rr_ptr    <= '0;
         out_grant <= '0;
      end else begin
         state <= state_nx;
         if (state == IDLE && (|req_valid)) out_grant <= pick;
         if (xfer && sel_tail) begin
            rr_ptr <= (out_grant == GW'(N - 1)) ? '0 : out_grant + GW'(1);
         end
      end
   end

   // Credit counter; a return at full credit is dropped and flagged.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         credits    <= CW'(CREDITS);
         credit_err <= 1'b0;
      end else begin
         if (xfer && !credit_return) begin
            credits <= credits - CW'(1);
         end else if (!xfer && credit_return) begin
            if (credits == CW'(CREDITS)) credit_err <= 1'b1;
            else                          credits    <= credits + CW'(1);
         end
      end
   end

endmodule

// File: tb/tb_router_port_arbiter.sv
// Directed testbench for router_port_arbiter (N=4, W=8, CREDITS=4).
module tb_router_port_arbiter;

   localparam int unsigned N  = 4;
   localparam int unsigned W  = 8;
   localparam int unsigned GW = 2;
   localparam int unsigned CW = 3;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    req_valid;
   logic [N-1:0]    req_tail;
   logic [N*W-1:0]  req_data;
   logic [N-1:0]    req_ready;
   logic            out_valid;
   logic [W-1:0]    out_data;
   logic            out_tail;
   logic [GW-1:0]   out_grant;
   logic            credit_return;
   logic [CW-1:0]   credits;
   logic            busy;
   logic            credit_err;

   int n_cmp = 0;
   int n_mis = 0;

   router_port_arbiter #(.N(N), .W(W), .CREDITS(4)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_tail(req_tail), .req_data(req_data),
      .req_ready(req_ready),
      .out_valid(out_valid), .out_data(out_data), .out_tail(out_tail),
      .out_grant(out_grant),
      .credit_return(credit_return), .credits(credits),
      .busy(busy), .credit_err(credit_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%0h, need 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic lane(input int i, input logic v, input logic t, input logic [W-1:0] d);
      req_valid[i]       = v;
      req_tail[i]        = t;
      req_data[i*W +: W] = d;
   endtask

   task automatic clear_in;
      req_valid     = '0;
      req_tail      = '0;
      req_data      = '0;
      credit_return = 1'b0;
   endtask

   // Reset is asynchronous: outputs are checked before any clock edge.
   task automatic do_reset;
      rst = 1'b1;
      #1;
      chk("rst_credits", 32'(credits), 4);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_valid", 32'(out_valid), 0);
      chk("rst_ready", 32'(req_ready), 0);
      chk("rst_grant", 32'(out_grant), 0);
      chk("rst_err", 32'(credit_err), 0);
      chk("rst_tail", 32'(out_tail), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      clear_in();
      #12;
      do_reset();

      // Single 3-flit packet from requester 2
      lane(2, 1'b1, 1'b0, 8'hA1);
      #1;
      chk("t1_idle_valid", 32'(out_valid), 0);
      chk("t1_idle_ready", 32'(req_ready), 0);
      tick();
      chk("t1_grant", 32'(out_grant), 2);
      chk("t1_busy", 32'(busy), 1);
      chk("t1_f0_valid", 32'(out_valid), 1);
      chk("t1_f0_data", 32'(out_data), 'hA1);
      chk("t1_f0_ready", 32'(req_ready), 'b0100);
      chk("t1_f0_tail", 32'(out_tail), 0);
      chk("t1_f0_cred", 32'(credits), 4);
      tick();
      lane(2, 1'b1, 1'b0, 8'hA2);
      #1;
      chk("t1_f1_valid", 32'(out_valid), 1);
      chk("t1_f1_data", 32'(out_data), 'hA2);
      chk("t1_f1_cred", 32'(credits), 3);
      tick();
      lane(2, 1'b1, 1'b1, 8'hA3);
      #1;
      chk("t1_f2_valid", 32'(out_valid), 1);
      chk("t1_f2_data", 32'(out_data), 'hA3);
      chk("t1_f2_tail", 32'(out_tail), 1);
      chk("t1_f2_cred", 32'(credits), 2);
      tick();
      lane(2, 1'b0, 1'b0, 8'h00);
      #1;
      chk("t1_after_busy", 32'(busy), 0);
      chk("t1_after_valid", 32'(out_valid), 0);
      chk("t1_after_cred", 32'(credits), 1);
      // rr_ptr is now 3: requester 3 beats requester 0
      lane(0, 1'b1, 1'b1, 8'hB0);
      lane(3, 1'b1, 1'b1, 8'hB3);
      tick();
      chk("t1_rr_grant", 32'(out_grant), 3);
      chk("t1_rr_data", 32'(out_data), 'hB3);
      tick();
      clear_in();
      #1;
      chk("t1_end_cred", 32'(credits), 0);

      // All requesters valid, 1-flit packets, credit returned every cycle
      clear_in();
      do_reset();
      for (int i = 0; i < int'(N); i++) lane(i, 1'b1, 1'b1, 8'(16 + i));
      credit_return = 1'b1;
      for (int p = 0; p < 6; p++) begin
         #1;
         chk($sformatf("t2_p%0d_idle_valid", p), 32'(out_valid), 0);
         chk($sformatf("t2_p%0d_idle_cred", p), 32'(credits), 4);
         tick();
         chk($sformatf("t2_p%0d_grant", p), 32'(out_grant), 32'(p % 4));
         chk($sformatf("t2_p%0d_valid", p), 32'(out_valid), 1);
         chk($sformatf("t2_p%0d_data", p), 32'(out_data), 32'(16 + p % 4));
         chk($sformatf("t2_p%0d_cred", p), 32'(credits), 4);
         tick();
      end
      chk("t2_err", 32'(credit_err), 1);

      // Credit exhaustion on a 6-flit packet from requester 1
      clear_in();
      do_reset();
      lane(1, 1'b1, 1'b0, 8'h30);
      tick();
      for (int f = 0; f < 4; f++) begin
         lane(1, 1'b1, 1'b0, 8'(8'h30 + f));
         #1;
         chk($sformatf("t3_f%0d_valid", f), 32'(out_valid), 1);
         chk($sformatf("t3_f%0d_data", f), 32'(out_data), 32'(8'h30 + f));
         chk($sformatf("t3_f%0d_cred", f), 32'(credits), 32'(4 - f));
         tick();
      end
      lane(1, 1'b1, 1'b0, 8'h34);
      #1;
      chk("t3_stall_cred", 32'(credits), 0);
      chk("t3_stall_valid", 32'(out_valid), 0);
      chk("t3_stall_ready", 32'(req_ready), 0);
      chk("t3_stall_busy", 32'(busy), 1);
      tick();
      chk("t3_stall2_valid", 32'(out_valid), 0);
      credit_return = 1'b1;
      #1;
      chk("t3_pulse_valid", 32'(out_valid), 0);
      tick();
      credit_return = 1'b0;
      #1;
      chk("t3_resume_cred", 32'(credits), 1);
      chk("t3_resume_valid", 32'(out_valid), 1);
      chk("t3_resume_data", 32'(out_data), 'h34);
      chk("t3_resume_ready", 32'(req_ready), 'b0010);
      tick();
      lane(1, 1'b1, 1'b1, 8'h35);
      #1;
      chk("t3_again_cred", 32'(credits), 0);
      chk("t3_again_valid", 32'(out_valid), 0);

      // Locked requester 0 idles mid-packet while requester 3 waits
      clear_in();
      do_reset();
      lane(0, 1'b1, 1'b0, 8'h40);
      lane(3, 1'b1, 1'b1, 8'h4F);
      tick();
      chk("t4_grant", 32'(out_grant), 0);
      chk("t4_f0_data", 32'(out_data), 'h40);
      chk("t4_f0_valid", 32'(out_valid), 1);
      tick();
      lane(0, 1'b0, 1'b0, 8'h00);
      for (int c = 0; c < 3; c++) begin
         #1;
         chk($sformatf("t4_gap%0d_valid", c), 32'(out_valid), 0);
         chk($sformatf("t4_gap%0d_ready", c), 32'(req_ready), 0);
         chk($sformatf("t4_gap%0d_grant", c), 32'(out_grant), 0);
         tick();
      end
      lane(0, 1'b1, 1'b0, 8'h41);
      #1;
      chk("t4_f1_data", 32'(out_data), 'h41);
      chk("t4_f1_cred", 32'(credits), 3);
      tick();
      lane(0, 1'b1, 1'b1, 8'h42);
      #1;
      chk("t4_f2_valid", 32'(out_valid), 1);
      chk("t4_f2_tail", 32'(out_tail), 1);
      tick();
      lane(0, 1'b0, 1'b0, 8'h00);
      #1;
      chk("t4_idle_busy", 32'(busy), 0);
      chk("t4_idle_cred", 32'(credits), 1);
      tick();
      chk("t4_next_grant", 32'(out_grant), 3);
      chk("t4_next_data", 32'(out_data), 'h4F);
      chk("t4_next_valid", 32'(out_valid), 1);

      // Reset mid-packet clears the round-robin pointer
      clear_in();
      do_reset();
      lane(1, 1'b1, 1'b1, 8'h51);
      tick();
      credit_return = 1'b1;
      #1;
      chk("t5_p1_grant", 32'(out_grant), 1);
      chk("t5_p1_valid", 32'(out_valid), 1);
      tick();
      credit_return = 1'b0;
      lane(1, 1'b0, 1'b0, 8'h00);
      lane(0, 1'b1, 1'b0, 8'h50);
      #1;
      chk("t5_idle_cred", 32'(credits), 4);
      tick();
      chk("t5_p0_grant", 32'(out_grant), 0);
      tick();
      #1;
      chk("t5_f1_cred", 32'(credits), 3);
      tick();
      chk("t5_mid_cred", 32'(credits), 2);
      chk("t5_mid_busy", 32'(busy), 1);
      do_reset();
      lane(2, 1'b1, 1'b1, 8'h52);
      lane(0, 1'b1, 1'b1, 8'h50);
      tick();
      chk("t5_post_grant", 32'(out_grant), 0);
      chk("t5_post_data", 32'(out_data), 'h50);

      // Sticky credit error from a return at full credit
      clear_in();
      do_reset();
      credit_return = 1'b1;
      #1;
      chk("t6_pre_err", 32'(credit_err), 0);
      tick();
      credit_return = 1'b0;
      #1;
      chk("t6_cred", 32'(credits), 4);
      chk("t6_err", 32'(credit_err), 1);
      tick();
      tick();
      chk("t6_err_hold", 32'(credit_err), 1);
      do_reset();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
